// File: rtl/m68k_bus_pkg.sv
// Shared types for the 68000 bus-cycle engine: one-hot FSM states, response codes and OE bundle.
package m68k_bus_pkg;

  typedef enum logic [12:0] {
    StIdle    = 13'h0001,
    StS0      = 13'h0002,
    StS1      = 13'h0004,
    StS2      = 13'h0008,
    StS3      = 13'h0010,
    StS4      = 13'h0020,
    StS5      = 13'h0040,
    StS6      = 13'h0080,
    StS7      = 13'h0100,
    StVmaWait = 13'h0200,
    StVmaEHi  = 13'h0400,
    StVmaELo  = 13'h0800,
    StVmaEnd  = 13'h1000
  } state_e;

  typedef enum logic [1:0] {
    StatusOk      = 2'b00,
    StatusBerr    = 2'b01,
    StatusTimeout = 2'b10,
    StatusIllegal = 2'b11
  } status_e;

  // A set bit drives the pad: strobes pulled low, rw driven low (write).
  typedef struct packed {
    logic a;
    logic d;
    logic fc;
    logic addr_strb;
    logic uds;
    logic lds;
    logic rw;
    logic vma;
  } oe_t;

  localparam oe_t OeNone = '0;

  function automatic oe_t drop_strobes(input oe_t oe);
    oe_t r;
    r           = oe;
    r.addr_strb = 1'b0;
    r.uds       = 1'b0;
    r.lds       = 1'b0;
    r.vma       = 1'b0;
    return r;
  endfunction

  // Beat 0 occupies the most significant used word.
  function automatic int unsigned word_slot(input int unsigned beats, input int unsigned beat);
    return beats - beat - 1;
  endfunction

endpackage

// File: rtl/m68k_bus_master_if.sv
// Request/response and Amiga pad signals of the bus master, with DUT and environment views.
interface m68k_bus_master_if #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned MAX_BEATS = 2
);
  localparam int unsigned BEAT_W = $clog2(MAX_BEATS + 1);
  localparam int unsigned DATA_W = 16 * MAX_BEATS;

  logic              req_valid;
  logic              req_ready;
  logic              req_read;
  logic [2:0]        req_fc;
  logic [ADDR_W-1:0] req_addr;
  logic [BEAT_W-1:0] req_beats;
  logic              req_uds;
  logic              req_lds;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [1:0]        rsp_status;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;

  logic              dtack_n;
  logic              berr_n;
  logic              vpa_n;
  logic [15:0]       din;
  logic [ADDR_W-2:0] a_out;
  logic [15:0]       d_out;
  logic [2:0]        fc_out;
  logic              a_oe, d_oe, fc_oe, as_oe, uds_oe, lds_oe, rw_oe, vma_oe;

  modport master (
    input  req_valid, req_read, req_fc, req_addr, req_beats, req_uds, req_lds, req_wdata,
    output req_ready, rsp_valid, rsp_status, rsp_rdata, busy,
    input  dtack_n, berr_n, vpa_n, din,
    output a_out, d_out, fc_out, a_oe, d_oe, fc_oe, as_oe, uds_oe, lds_oe, rw_oe, vma_oe
  );

  modport slave (
    output req_valid, req_read, req_fc, req_addr, req_beats, req_uds, req_lds, req_wdata,
    input  req_ready, rsp_valid, rsp_status, rsp_rdata, busy,
    output dtack_n, berr_n, vpa_n, din,
    input  a_out, d_out, fc_out, a_oe, d_oe, fc_oe, as_oe, uds_oe, lds_oe, rw_oe, vma_oe
  );
endinterface

// File: rtl/mc_clk_edge_detect.sv
// Oversamples a slow asynchronous clock on falling sys_clk and emits one-cycle edge pulses.
module mc_clk_edge_detect #(
  parameter int unsigned EDGE_TAP  = 6,
  parameter int unsigned LATCH_TAP = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o,
  output logic latch_o
);

  logic [EDGE_TAP:0] sr_q;

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= {sr_q[EDGE_TAP-1:0], sig_i};
    end
  end

  assign rise_o  =  sr_q[EDGE_TAP-1] & ~sr_q[EDGE_TAP];
  assign fall_o  = ~sr_q[EDGE_TAP-1] &  sr_q[EDGE_TAP];
  // Earlier tap sees the same falling edge first, so the latch pulse leads fall_o.
  assign latch_o = ~sr_q[LATCH_TAP] & sr_q[LATCH_TAP+1];

endmodule

// File: rtl/m68k_bus_master.sv
// 68000 bus-cycle engine: runs 1..MAX_BEATS word beats per request, ends on DTACK/BERR/VPA/timeout.
module m68k_bus_master
  import m68k_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned MAX_BEATS   = 2,
  parameter int unsigned EDGE_TAP    = 6,
  parameter int unsigned LATCH_TAP   = 3,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic               sys_clk_i,
  input  logic               sys_nreset_i,
  input  logic               clk_7m_i,
  input  logic               eclk_i,
  m68k_bus_master_if.master  bus_io
);

  localparam int unsigned BeatW = $clog2(MAX_BEATS + 1);
  localparam int unsigned DataW = 16 * MAX_BEATS;
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC + 1);

  logic mc_rise, mc_fall, mc_latch, e_rise, e_fall, e_latch_unused;
  logic req_a0_unused;

  mc_clk_edge_detect #(.EDGE_TAP(EDGE_TAP), .LATCH_TAP(LATCH_TAP)) u_mc_edge (
    .clk_i   (sys_clk_i),
    .rst_ni  (sys_nreset_i),
    .sig_i   (clk_7m_i),
    .rise_o  (mc_rise),
    .fall_o  (mc_fall),
    .latch_o (mc_latch)
  );

  mc_clk_edge_detect #(.EDGE_TAP(EDGE_TAP), .LATCH_TAP(LATCH_TAP)) u_e_edge (
    .clk_i   (sys_clk_i),
    .rst_ni  (sys_nreset_i),
    .sig_i   (eclk_i),
    .rise_o  (e_rise),
    .fall_o  (e_fall),
    .latch_o (e_latch_unused)
  );

  // Bus inputs are asynchronous to sys_clk.
  logic [1:0]  dtack_sync_q, berr_sync_q, vpa_sync_q;
  logic [15:0] din_s1_q, din_s2_q;

  always_ff @(posedge sys_clk_i or negedge sys_nreset_i) begin
    if (!sys_nreset_i) begin
      dtack_sync_q <= 2'b11;
      berr_sync_q  <= 2'b11;
      vpa_sync_q   <= 2'b11;
      din_s1_q     <= '0;
      din_s2_q     <= '0;
    end else begin
      dtack_sync_q <= {dtack_sync_q[0], bus_io.dtack_n};
      berr_sync_q  <= {berr_sync_q[0], bus_io.berr_n};
      vpa_sync_q   <= {vpa_sync_q[0], bus_io.vpa_n};
      din_s1_q     <= bus_io.din;
      din_s2_q     <= din_s1_q;
    end
  end

  state_e            state_q, state_d;
  logic [BeatW-1:0]  beats_q, beats_d, beat_q, beat_d;
  logic              read_q, read_d, uds_q, uds_d, lds_q, lds_d;
  logic [2:0]        fc_q, fc_d;
  logic [ADDR_W-2:0] addr_q, addr_d;
  logic [DataW-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
  status_e           status_q, status_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  oe_t               oe_q, oe_d;
  logic [15:0]       d_out_q, d_out_d;
  logic              illegal;
  int unsigned       slot;

  assign req_a0_unused = bus_io.req_addr[0];
  assign slot          = word_slot(32'(beats_q), 32'(beat_q));
  assign illegal = (bus_io.req_beats == '0) || (bus_io.req_beats > BeatW'(MAX_BEATS)) ||
                   ((bus_io.req_beats == BeatW'(1)) && !bus_io.req_uds && !bus_io.req_lds);

  always_comb begin
    state_d     = state_q;
    beats_d     = beats_q;
    beat_d      = beat_q;
    read_d      = read_q;
    uds_d       = uds_q;
    lds_d       = lds_q;
    fc_d        = fc_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    status_d    = status_q;
    rsp_valid_d = 1'b0;
    tmo_d       = tmo_q;
    oe_d        = oe_q;
    d_out_d     = d_out_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.req_valid) begin
          beats_d = bus_io.req_beats;
          beat_d  = '0;
          read_d  = bus_io.req_read;
          fc_d    = bus_io.req_fc;
          addr_d  = bus_io.req_addr[ADDR_W-1:1];
          wdata_d = bus_io.req_wdata;
          rdata_d = '0;
          uds_d   = (bus_io.req_beats == BeatW'(1)) ? bus_io.req_uds : 1'b1;
          lds_d   = (bus_io.req_beats == BeatW'(1)) ? bus_io.req_lds : 1'b1;
          if (illegal) begin
            status_d    = StatusIllegal;
            rsp_valid_d = 1'b1;
          end else begin
            status_d = StatusOk;
            state_d  = StS0;
          end
        end
      end
      StS0: begin
        if (!read_q) d_out_d = wdata_q[16*slot +: 16];
        oe_d.a  = 1'b1;
        oe_d.fc = 1'b1;
        state_d = StS1;
      end
      StS1: begin
        tmo_d = '0;
        if (mc_rise) begin
          oe_d.addr_strb = 1'b1;
          oe_d.rw        = !read_q;
          if (read_q) begin
            oe_d.uds = uds_q;
            oe_d.lds = lds_q;
          end
          state_d = StS2;
        end
      end
      StS2: begin
        if (mc_fall) begin
          oe_d.d  = !read_q;
          state_d = StS3;
        end
      end
      StS3: begin
        if (mc_rise) begin
          if (!read_q) begin
            oe_d.uds = uds_q;
            oe_d.lds = lds_q;
          end
          state_d = StS4;
        end
      end
      StS4: begin
        if (mc_fall) begin
          if (!berr_sync_q[1]) begin
            status_d = StatusBerr;
            oe_d     = drop_strobes(oe_q);
            state_d  = StS7;
          end else if (!dtack_sync_q[1]) begin
            state_d = StS5;
          end else if (!vpa_sync_q[1]) begin
            state_d = StVmaWait;
          end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
            status_d = StatusTimeout;
            oe_d     = drop_strobes(oe_q);
            state_d  = StS7;
          end else begin
            tmo_d = tmo_q + TmoW'(1);
          end
        end
      end
      StS5: begin
        if (mc_rise) state_d = StS6;
      end
      StS6: begin
        if (mc_latch && read_q) rdata_d[16*slot +: 16] = din_s2_q;
        if (mc_fall) begin
          oe_d    = drop_strobes(oe_q);
          state_d = StS7;
        end
      end
      StS7: begin
        if (mc_rise) begin
          oe_d = OeNone;
          if (status_q == StatusOk && (32'(beat_q) + 1 < 32'(beats_q))) begin
            beat_d  = beat_q + BeatW'(1);
            state_d = StS0;
          end else begin
            rsp_valid_d = 1'b1;
            state_d     = StIdle;
          end
        end
      end
      StVmaWait: begin
        if (mc_rise) begin
          oe_d.vma = 1'b1;
          state_d  = StVmaEHi;
        end
      end
      StVmaEHi, StVmaELo: begin
        if (!berr_sync_q[1]) begin
          status_d = StatusBerr;
          oe_d     = drop_strobes(oe_q);
          state_d  = StS7;
        end else if (state_q == StVmaEHi && e_rise) begin
          state_d = StVmaELo;
        end else if (state_q == StVmaELo && e_fall) begin
          if (read_q) rdata_d[16*slot +: 16] = din_s2_q;
          state_d = StVmaEnd;
        end
      end
      StVmaEnd: begin
        if (mc_fall) begin
          oe_d    = drop_strobes(oe_q);
          state_d = StS7;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_nreset_i) begin
    if (!sys_nreset_i) begin
      state_q     <= StIdle;
      beats_q     <= '0;
      beat_q      <= '0;
      read_q      <= 1'b0;
      uds_q       <= 1'b0;
      lds_q       <= 1'b0;
      fc_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      status_q    <= StatusOk;
      rsp_valid_q <= 1'b0;
      tmo_q       <= '0;
      oe_q        <= OeNone;
      d_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      beats_q     <= beats_d;
      beat_q      <= beat_d;
      read_q      <= read_d;
      uds_q       <= uds_d;
      lds_q       <= lds_d;
      fc_q        <= fc_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      status_q    <= status_d;
      rsp_valid_q <= rsp_valid_d;
      tmo_q       <= tmo_d;
      oe_q        <= oe_d;
      d_out_q     <= d_out_d;
    end
  end

  assign bus_io.req_ready  = (state_q == StIdle);
  assign bus_io.busy       = (state_q != StIdle);
  assign bus_io.rsp_valid  = rsp_valid_q;
  assign bus_io.rsp_status = status_q;
  assign bus_io.rsp_rdata  = rdata_q;
  // Word address wraps naturally at the top of the space.
  assign bus_io.a_out      = addr_q + (ADDR_W-1)'(beat_q);
  assign bus_io.d_out      = d_out_q;
  assign bus_io.fc_out     = fc_q;
  assign bus_io.a_oe       = oe_q.a;
  assign bus_io.d_oe       = oe_q.d;
  assign bus_io.fc_oe      = oe_q.fc;
  assign bus_io.as_oe      = oe_q.addr_strb;
  assign bus_io.uds_oe     = oe_q.uds;
  assign bus_io.lds_oe     = oe_q.lds;
  assign bus_io.rw_oe      = oe_q.rw;
  assign bus_io.vma_oe     = oe_q.vma;

endmodule

// File: tb/tb_m68k_bus_master.sv
// Directed bench for m68k_bus_master: a simple bus slave answers with DTACK, BERR, VPA or nothing.
module tb_m68k_bus_master;

  logic sys_clk    = 1'b0;
  logic sys_nreset = 1'b0;
  logic clk_7m     = 1'b0;
  logic eclk       = 1'b0;

  always #5 sys_clk = ~sys_clk;
  initial begin
    #3;
    forever #100 clk_7m = ~clk_7m;
  end
  initial begin
    #7;
    forever #800 eclk = ~eclk;
  end

  m68k_bus_master_if #(.ADDR_W(24), .MAX_BEATS(2)) bif ();

  m68k_bus_master #(
    .ADDR_W      (24),
    .MAX_BEATS   (2),
    .EDGE_TAP    (6),
    .LATCH_TAP   (3),
    .TIMEOUT_CYC (16)
  ) dut (
    .sys_clk_i    (sys_clk),
    .sys_nreset_i (sys_nreset),
    .clk_7m_i     (clk_7m),
    .eclk_i       (eclk),
    .bus_io       (bif)
  );

  // Slave response mode: 0 none, 1 DTACK, 2 BERR, 3 VPA.
  int          mode  = 1;
  logic [15:0] din_v = 16'h0000;

  assign bif.dtack_n = !(mode == 1 && bif.as_oe);
  assign bif.berr_n  = !(mode == 2 && bif.as_oe);
  assign bif.vpa_n   = !(mode == 3 && bif.as_oe);
  assign bif.din     = din_v;

  logic [22:0] as_addr_log[$];
  logic [15:0] wr_data_log[$];
  int   uds_cnt  = 0;
  int   vma_cnt  = 0;
  int   rw_cnt   = 0;
  int   oe_cnt   = 0;
  int   fall_cnt = 0;
  logic as_prev  = 1'b0;
  logic d_prev   = 1'b0;

  always @(negedge sys_clk) begin
    if (bif.as_oe && !as_prev) as_addr_log.push_back(bif.a_out);
    if (bif.d_oe && !d_prev) wr_data_log.push_back(bif.d_out);
    as_prev <= bif.as_oe;
    d_prev  <= bif.d_oe;
    if (bif.uds_oe) uds_cnt <= uds_cnt + 1;
    if (bif.vma_oe) vma_cnt <= vma_cnt + 1;
    if (bif.rw_oe) rw_cnt <= rw_cnt + 1;
    if (oes() != 8'h00) oe_cnt <= oe_cnt + 1;
  end

  always @(negedge clk_7m) fall_cnt <= fall_cnt + 1;

  int total = 0;
  int bad   = 0;

  function automatic logic [7:0] oes();
    return {bif.a_oe, bif.d_oe, bif.fc_oe, bif.as_oe, bif.uds_oe, bif.lds_oe, bif.rw_oe,
            bif.vma_oe};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic [2:0] fc, input logic [23:0] addr,
                       input logic [1:0] beats, input logic uds, input logic lds,
                       input logic [31:0] wd);
    @(negedge sys_clk);
    bif.req_read  = rd;
    bif.req_fc    = fc;
    bif.req_addr  = addr;
    bif.req_beats = beats;
    bif.req_uds   = uds;
    bif.req_lds   = lds;
    bif.req_wdata = wd;
    bif.req_valid = 1'b1;
    @(negedge sys_clk);
    bif.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic got, output logic [1:0] st, output logic [31:0] rd);
    got = 1'b0;
    st  = 2'b00;
    rd  = '0;
    for (int i = 0; i < 1000; i++) begin
      if (bif.rsp_valid) begin
        got = 1'b1;
        st  = bif.rsp_status;
        rd  = bif.rsp_rdata;
        break;
      end
      @(negedge sys_clk);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, w0, u0, v0, o0, f0, r0;
    logic got;
    logic [1:0] st;
    logic [31:0] rd;

    bif.req_valid = 1'b0;
    bif.req_read  = 1'b0;
    bif.req_fc    = '0;
    bif.req_addr  = '0;
    bif.req_beats = '0;
    bif.req_uds   = 1'b0;
    bif.req_lds   = 1'b0;
    bif.req_wdata = '0;

    repeat (3) @(negedge sys_clk);
    chk("reset_ready", 64'(bif.req_ready), 64'd1);
    chk("reset_busy", 64'(bif.busy), 64'd0);
    chk("reset_rsp_valid", 64'(bif.rsp_valid), 64'd0);
    chk("reset_status", 64'(bif.rsp_status), 64'd0);
    chk("reset_rdata", 64'(bif.rsp_rdata), 64'd0);
    chk("reset_oes", 64'(oes()), 64'd0);
    sys_nreset = 1'b1;
    repeat (10) @(negedge sys_clk);

    // 1-beat byte read, lower lane only, DTACK.
    mode = 1; din_v = 16'h00AB;
    a0 = as_addr_log.size(); u0 = uds_cnt; r0 = rw_cnt;
    issue(1'b1, 3'b101, 24'hBFE001, 2'd1, 1'b0, 1'b1, 32'h0);
    chk("t1_busy", 64'(bif.busy), 64'd1);
    wait_rsp(got, st, rd);
    chk("t1_got_rsp", 64'(got), 64'd1);
    chk("t1_status", 64'(st), 64'd0);
    chk("t1_rdata", 64'(rd), 64'h0000_00AB);
    chk("t1_uds_never", 64'(uds_cnt - u0), 64'd0);
    chk("t1_rw_never", 64'(rw_cnt - r0), 64'd0);
    chk("t1_as_count", 64'(as_addr_log.size() - a0), 64'd1);
    chk("t1_addr", 64'(as_addr_log[a0]), 64'h5F_F000);
    @(negedge sys_clk);
    chk("t1_rsp_one_cycle", 64'(bif.rsp_valid), 64'd0);

    // 2-beat read with BERR on beat 0.
    mode = 2;
    a0 = as_addr_log.size();
    issue(1'b1, 3'b110, 24'h000400, 2'd2, 1'b1, 1'b1, 32'h0);
    wait_rsp(got, st, rd);
    chk("t3_got_rsp", 64'(got), 64'd1);
    chk("t3_status", 64'(st), 64'd1);
    chk("t3_rdata", 64'(rd), 64'd0);
    chk("t3_as_count", 64'(as_addr_log.size() - a0), 64'd1);

    // 2-beat write.
    mode = 1;
    a0 = as_addr_log.size(); w0 = wr_data_log.size();
    issue(1'b0, 3'b101, 24'hDFF180, 2'd2, 1'b0, 1'b0, 32'h1234_5678);
    wait_rsp(got, st, rd);
    chk("t2_got_rsp", 64'(got), 64'd1);
    chk("t2_status", 64'(st), 64'd0);
    chk("t2_as_count", 64'(as_addr_log.size() - a0), 64'd2);
    chk("t2_wr_count", 64'(wr_data_log.size() - w0), 64'd2);
    chk("t2_addr0", 64'(as_addr_log[a0]), 64'h6F_F8C0);
    chk("t2_addr1", 64'(as_addr_log[a0+1]), 64'h6F_F8C1);
    chk("t2_data0", 64'(wr_data_log[w0]), 64'h1234);
    chk("t2_data1", 64'(wr_data_log[w0+1]), 64'h5678);

    // VPA / 6800 E-cycle read.
    mode = 3; din_v = 16'h0042;
    v0 = vma_cnt;
    issue(1'b1, 3'b101, 24'hBFE001, 2'd1, 1'b0, 1'b1, 32'h0);
    wait_rsp(got, st, rd);
    chk("t4_got_rsp", 64'(got), 64'd1);
    chk("t4_status", 64'(st), 64'd0);
    chk("t4_rdata", 64'(rd), 64'h0000_0042);
    chk("t4_vma_seen", 64'((vma_cnt - v0) > 0), 64'd1);
    chk("t4_vma_released", 64'(bif.vma_oe), 64'd0);

    // No response: timeout after 16 clk_7m falls in S4, plus the S2 fall.
    mode = 0;
    @(negedge clk_7m);
    repeat (7) @(negedge sys_clk);
    f0 = fall_cnt;
    issue(1'b1, 3'b001, 24'h000100, 2'd1, 1'b1, 1'b1, 32'h0);
    wait_rsp(got, st, rd);
    chk("t5_got_rsp", 64'(got), 64'd1);
    chk("t5_status", 64'(st), 64'd2);
    chk("t5_fall_count", 64'(fall_cnt - f0), 64'd17);
    chk("t5_oes_after", 64'(oes()), 64'd0);

    // Illegal requests answer the next cycle without touching the bus.
    o0 = oe_cnt;
    issue(1'b1, 3'b001, 24'h000200, 2'd0, 1'b1, 1'b1, 32'h0);
    chk("t6_beats0_valid", 64'(bif.rsp_valid), 64'd1);
    chk("t6_beats0_status", 64'(bif.rsp_status), 64'd3);
    issue(1'b1, 3'b001, 24'h000200, 2'd3, 1'b1, 1'b1, 32'h0);
    chk("t6_beats3_valid", 64'(bif.rsp_valid), 64'd1);
    chk("t6_beats3_status", 64'(bif.rsp_status), 64'd3);
    issue(1'b0, 3'b001, 24'h000200, 2'd1, 1'b0, 1'b0, 32'h0);
    chk("t6_nolane_valid", 64'(bif.rsp_valid), 64'd1);
    chk("t6_nolane_status", 64'(bif.rsp_status), 64'd3);
    repeat (5) @(negedge sys_clk);
    chk("t6_no_oe_activity", 64'(oe_cnt - o0), 64'd0);

    // Reset while waiting in S4 releases the bus immediately.
    mode = 0;
    issue(1'b1, 3'b010, 24'h001000, 2'd1, 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 200 && !bif.as_oe; i++) @(negedge sys_clk);
    repeat (25) @(negedge sys_clk);
    chk("t7_as_before_reset", 64'(bif.as_oe), 64'd1);
    sys_nreset = 1'b0;
    #1;
    chk("t7_oes_in_reset", 64'(oes()), 64'd0);
    chk("t7_ready_in_reset", 64'(bif.req_ready), 64'd1);
    repeat (2) @(negedge sys_clk);
    sys_nreset = 1'b1;
    repeat (5) @(negedge sys_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
